// File: rtl/cpu_regbank.sv
// CPU-mapped register bank: shadowed registers copied to their active copies on a
// commit, plus self-clearing strobe registers that hold their value for PULSE_LEN cycles.
module cpu_regbank #(
    parameter int                            NUM_REGS   = 8,
    parameter int                            DATA_W     = 32,
    parameter int                            ADDR_W     = 9,
    parameter int                            BASE_ADDR  = 0,
    parameter logic [NUM_REGS-1:0]           PULSE_MASK = 'h03,
    parameter int                            PULSE_LEN  = 4,
    parameter logic [NUM_REGS*DATA_W-1:0]    RESET_VAL  = '0
) (
    input  logic                       clk,
    input  logic                       nRST,
    input  logic                       cpu_wr_n,
    input  logic                       cpu_rd_n,
    input  logic [ADDR_W-1:0]          cpu_addr,
    input  logic [DATA_W/8-1:0]        cpu_be,
    input  logic [DATA_W-1:0]          cpu_wdata,
    output logic [DATA_W-1:0]          cpu_rdata,
    output logic                       cpu_rvalid,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    output logic                       commit_pulse,
    output logic                       err_unmapped
);

    localparam int NB = DATA_W / 8;

    logic [ADDR_W-1:0]          w_off;
    logic                       w_in_range;
    logic                       w_is_reg;
    logic                       w_is_ctrl;
    logic                       w_wr;
    logic                       w_rd;
    logic                       w_ctrl_wr;
    logic                       w_commit;
    logic                       w_err_clr;
    logic                       w_err_set;
    logic [DATA_W-1:0]          w_mask;
    logic [NUM_REGS-1:0]        w_sel;
    logic [NUM_REGS-1:0]        w_shadow_wr;
    logic [NUM_REGS*DATA_W-1:0] w_rd_flat;
    logic [DATA_W-1:0]          w_rd_mux;

    logic [DATA_W-1:0]          r_rdata;
    logic                       r_rvalid;
    logic                       r_commit;
    logic                       r_err;
    logic                       r_dirty;

    // Addresses below BASE_ADDR must not wrap into the mapped window.
    assign w_off      = cpu_addr - ADDR_W'(BASE_ADDR);
    assign w_in_range = {1'b0, cpu_addr} >= (ADDR_W + 1)'(BASE_ADDR);
    assign w_is_reg   = w_in_range && (w_off < ADDR_W'(NUM_REGS));
    assign w_is_ctrl  = w_in_range && (w_off == ADDR_W'(NUM_REGS));

    // A write wins over a simultaneous read; the read is then dropped.
    assign w_wr      = ~cpu_wr_n;
    assign w_rd      = ~cpu_rd_n & cpu_wr_n;
    assign w_ctrl_wr = w_wr & w_is_ctrl & cpu_be[0];
    assign w_commit  = w_ctrl_wr & cpu_wdata[0];
    assign w_err_clr = w_ctrl_wr & cpu_wdata[1];
    assign w_err_set = (w_wr | w_rd) & ~w_is_reg & ~w_is_ctrl;

    for (genvar b = 0; b < NB; b++) begin : g_mask
        assign w_mask[b*8 +: 8] = {8{cpu_be[b]}};
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        assign w_sel[i] = w_wr & w_is_reg & (w_off == ADDR_W'(i));

        if (PULSE_MASK[i]) begin : g_strobe
            logic [DATA_W-1:0] r_val;
            logic [7:0]        r_hold;

            always_ff @(posedge clk or negedge nRST) begin
                if (!nRST) begin
                    r_val  <= '0;
                    r_hold <= '0;
                end else if (w_sel[i]) begin
                    r_val  <= (r_val & ~w_mask) | (cpu_wdata & w_mask);
                    r_hold <= 8'(PULSE_LEN);
                end else if (r_hold != 8'd0) begin
                    r_hold <= r_hold - 8'd1;
                    if (r_hold == 8'd1) begin
                        r_val <= '0;
                    end
                end
            end

            assign w_shadow_wr[i]              = 1'b0;
            assign w_rd_flat[i*DATA_W +: DATA_W] = r_val;
            assign reg_out[i*DATA_W +: DATA_W]   = r_val;
        end else begin : g_shadow
            localparam logic [DATA_W-1:0] L_RST = RESET_VAL[i*DATA_W +: DATA_W];
            logic [DATA_W-1:0] r_shadow;
            logic [DATA_W-1:0] r_active;

            always_ff @(posedge clk or negedge nRST) begin
                if (!nRST) begin
                    r_shadow <= L_RST;
                    r_active <= L_RST;
                end else begin
                    if (w_sel[i]) begin
                        r_shadow <= (r_shadow & ~w_mask) | (cpu_wdata & w_mask);
                    end
                    if (w_commit) begin
                        r_active <= r_shadow;
                    end
                end
            end

            assign w_shadow_wr[i]              = w_sel[i] & (|cpu_be);
            assign w_rd_flat[i*DATA_W +: DATA_W] = r_shadow;
            assign reg_out[i*DATA_W +: DATA_W]   = r_active;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (w_is_reg) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_off == ADDR_W'(k)) begin
                    w_rd_mux = w_rd_flat[k*DATA_W +: DATA_W];
                end
            end
        end else if (w_is_ctrl) begin
            w_rd_mux = {{(DATA_W-2){1'b0}}, r_err, r_dirty};
        end
    end

    // Read handshake: cpu_rvalid pulses one cycle after each accepted read
    // (cpu_rd_n=0, cpu_wr_n=1) with cpu_rdata valid alongside; no backpressure.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_commit <= 1'b0;
            r_err    <= 1'b0;
            r_dirty  <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            r_commit <= w_commit;
            if (w_rd) begin
                r_rdata <= w_rd_mux;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end
            if (w_commit) begin
                r_dirty <= 1'b0;
            end else if (|w_shadow_wr) begin
                r_dirty <= 1'b1;
            end
        end
    end

    assign cpu_rdata    = r_rdata;
    assign cpu_rvalid   = r_rvalid;
    assign commit_pulse = r_commit;
    assign err_unmapped = r_err;

endmodule

// File: tb/tb_cpu_regbank.sv
// Directed and randomized bench for cpu_regbank against a cycle-time reference model.
module tb_cpu_regbank;

    localparam int            NR    = 8;
    localparam int            DW    = 32;
    localparam int            AW    = 9;
    localparam int            PL    = 4;
    localparam logic [NR-1:0] PMASK = 8'h03;

    logic              clk       = 1'b0;
    logic              nRST      = 1'b0;
    logic              cpu_wr_n  = 1'b1;
    logic              cpu_rd_n  = 1'b1;
    logic [AW-1:0]     cpu_addr  = '0;
    logic [DW/8-1:0]   cpu_be    = '0;
    logic [DW-1:0]     cpu_wdata = '0;
    logic [DW-1:0]     cpu_rdata;
    logic              cpu_rvalid;
    logic [NR*DW-1:0]  reg_out;
    logic              commit_pulse;
    logic              err_unmapped;

    always #5 clk = ~clk;

    cpu_regbank #(
        .NUM_REGS  (NR),
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .BASE_ADDR (0),
        .PULSE_MASK(PMASK),
        .PULSE_LEN (PL),
        .RESET_VAL ('0)
    ) dut (
        .clk         (clk),
        .nRST        (nRST),
        .cpu_wr_n    (cpu_wr_n),
        .cpu_rd_n    (cpu_rd_n),
        .cpu_addr    (cpu_addr),
        .cpu_be      (cpu_be),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_rvalid  (cpu_rvalid),
        .reg_out     (reg_out),
        .commit_pulse(commit_pulse),
        .err_unmapped(err_unmapped)
    );

    // Reference model: strobe registers are modelled by the time of their last write.
    logic [DW-1:0] m_shadow [NR];
    logic [DW-1:0] m_active [NR];
    logic [DW-1:0] m_sval   [NR];
    int            m_last   [NR];
    logic          m_dirty;
    logic          m_err;
    logic          m_commit;
    logic          m_rvalid;
    int            cyc;
    logic [DW-1:0] exp_q[$];

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                            input logic [DW/8-1:0] be);
        logic [DW-1:0] r;
        r = old_v;
        for (int b = 0; b < DW/8; b++) begin
            if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] strobe_at(input int i, input int t);
        return (t - m_last[i] < PL) ? m_sval[i] : '0;
    endfunction

    function automatic logic [NR*DW-1:0] exp_reg_out();
        logic [NR*DW-1:0] r;
        for (int i = 0; i < NR; i++) begin
            r[i*DW +: DW] = PMASK[i] ? strobe_at(i, cyc) : m_active[i];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] reg_of(input int i);
        return reg_out[i*DW +: DW];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
            m_sval[i]   = '0;
            m_last[i]   = -1000;
        end
        m_dirty  = 1'b0;
        m_err    = 1'b0;
        m_commit = 1'b0;
        m_rvalid = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        int   off;
        logic is_reg;
        logic is_ctrl;
        logic [DW-1:0] rv;
        cyc++;
        off      = int'(cpu_addr);
        is_reg   = off < NR;
        is_ctrl  = off == NR;
        m_commit = 1'b0;
        m_rvalid = 1'b0;
        if (!cpu_rd_n && cpu_wr_n) begin
            if (is_reg) rv = PMASK[off] ? strobe_at(off, cyc - 1) : m_shadow[off];
            else if (is_ctrl) rv = {30'd0, m_err, m_dirty};
            else rv = '0;
            m_rvalid = 1'b1;
            exp_q.push_back(rv);
        end
        if (!cpu_wr_n) begin
            if (is_reg && PMASK[off]) begin
                m_sval[off] = merge(strobe_at(off, cyc - 1), cpu_wdata, cpu_be);
                m_last[off] = cyc;
            end else if (is_reg) begin
                m_shadow[off] = merge(m_shadow[off], cpu_wdata, cpu_be);
                if (cpu_be != '0) m_dirty = 1'b1;
            end else if (is_ctrl && cpu_be[0]) begin
                if (cpu_wdata[0]) begin
                    for (int i = 0; i < NR; i++) begin
                        if (!PMASK[i]) m_active[i] = m_shadow[i];
                    end
                    m_dirty  = 1'b0;
                    m_commit = 1'b1;
                end
                if (cpu_wdata[1]) m_err = 1'b0;
            end
        end
        if (!is_reg && !is_ctrl && (!cpu_wr_n || !cpu_rd_n)) m_err = 1'b1;
    endtask

    task automatic check_all();
        check("reg_out", reg_out, exp_reg_out());
        check("rvalid", cpu_rvalid, m_rvalid);
        check("commit_pulse", commit_pulse, m_commit);
        check("err_unmapped", err_unmapped, m_err);
        if (m_rvalid) check("rdata", cpu_rdata, exp_q.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        if (nRST) model_edge();
        #1;
        check_all();
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
        cpu_addr = AW'(a); cpu_wdata = d; cpu_be = be; cpu_wr_n = 1'b0; cpu_rd_n = 1'b1;
        step();
        cpu_wr_n = 1'b1;
    endtask

    task automatic rd(input int a);
        cpu_addr = AW'(a); cpu_rd_n = 1'b0; cpu_wr_n = 1'b1;
        step();
        cpu_rd_n = 1'b1;
    endtask

    task automatic idle();
        cpu_wr_n = 1'b1; cpu_rd_n = 1'b1;
        step();
    endtask

    initial begin
        int n_high;
        int sel;
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        model_reset();

        #1;
        check("rst_reg_out", reg_out, 256'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_rvalid", cpu_rvalid, 1'b0);
        check("rst_commit", commit_pulse, 1'b0);
        check("rst_err", err_unmapped, 1'b0);
        #20;
        nRST = 1'b1;
        idle();

        // Shadow write is invisible on reg_out until commit.
        wr(4, 32'hA5A5A5A5, 4'b0011);
        check("r4_before_commit", reg_of(4), 32'h0);
        wr(NR, 32'h1, 4'b0001);
        check("r4_after_commit", reg_of(4), 32'h0000A5A5);
        check("commit_high", commit_pulse, 1'b1);
        idle();
        check("commit_one_cycle", commit_pulse, 1'b0);

        // Strobe hold length, then extension by a rewrite two cycles in.
        n_high = 0;
        wr(0, 32'h1, 4'hF);
        if (reg_of(0) == 32'h1) n_high++;
        repeat (5) begin
            idle();
            if (reg_of(0) == 32'h1) n_high++;
        end
        check("strobe_len", n_high, 4);
        check("strobe_cleared", reg_of(0), 32'h0);
        n_high = 0;
        wr(0, 32'h1, 4'hF);
        if (reg_of(0) == 32'h1) n_high++;
        idle();
        if (reg_of(0) == 32'h1) n_high++;
        wr(0, 32'h1, 4'hF);
        if (reg_of(0) == 32'h1) n_high++;
        repeat (5) begin
            idle();
            if (reg_of(0) == 32'h1) n_high++;
        end
        check("strobe_extended", n_high, 6);

        // Read-back of an uncommitted shadow.
        wr(3, 32'h12345678, 4'hF);
        rd(3);
        check("rd3_rvalid", cpu_rvalid, 1'b1);
        check("rd3_rdata", cpu_rdata, 32'h12345678);
        check("rd3_active", reg_of(3), 32'h0);
        idle();
        check("rd3_rvalid_drop", cpu_rvalid, 1'b0);

        // Unmapped access and error clearing through CTRL.
        wr(NR, 32'h1, 4'b0001);
        wr(20, 32'hFFFFFFFF, 4'hF);
        check("unmapped_err", err_unmapped, 1'b1);
        rd(NR);
        check("ctrl_read", cpu_rdata, 32'h2);
        wr(NR, 32'h2, 4'b0001);
        check("err_cleared", err_unmapped, 1'b0);

        // Simultaneous write and read: write happens, read is dropped.
        cpu_addr = AW'(5); cpu_wdata = 32'hCAFEF00D; cpu_be = 4'hF;
        cpu_wr_n = 1'b0; cpu_rd_n = 1'b0;
        step();
        check("wrrd_no_rvalid", cpu_rvalid, 1'b0);
        cpu_wr_n = 1'b1;
        repeat (3) begin
            step();
            check("burst_rvalid", cpu_rvalid, 1'b1);
            check("burst_rdata", cpu_rdata, 32'hCAFEF00D);
        end
        cpu_rd_n = 1'b1;
        idle();

        // Reset in the middle of a strobe hold.
        wr(0, 32'h1, 4'hF);
        idle();
        #2;
        nRST = 1'b0;
        #1;
        check("rst_mid_hold_r0", reg_of(0), 32'h0);
        check("rst_mid_rvalid", cpu_rvalid, 1'b0);
        model_reset();
        idle();
        idle();
        nRST = 1'b1;
        n_high = 0;
        repeat (6) begin
            idle();
            if (reg_of(0) != 32'h0) n_high++;
        end
        check("no_pulse_after_rst", n_high, 0);

        // Randomized traffic.
        repeat (400) begin
            sel = $urandom_range(0, 11);
            if (sel <= 8) cpu_addr = AW'(sel);
            else if (sel == 9) cpu_addr = AW'(20);
            else if (sel == 10) cpu_addr = AW'(511);
            else cpu_addr = AW'(9);
            cpu_wdata = $urandom;
            cpu_be    = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: begin cpu_wr_n = 1'b1; cpu_rd_n = 1'b1; end
                1: begin cpu_wr_n = 1'b0; cpu_rd_n = 1'b1; end
                2: begin cpu_wr_n = 1'b1; cpu_rd_n = 1'b0; end
                default: begin cpu_wr_n = 1'b0; cpu_rd_n = 1'b0; end
            endcase
            step();
        end
        idle();
        check("exp_q_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
